// File: rtl/cus43_tile_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : cus43_tile_gen_if
//  Description : Signal bundle for the CUS43 tile generator: fetch-phase
//                strobe and slot qualifiers, graphics/attribute data, CPU
//                register write port, flip control, upstream cascade pixel
//                and merged output pixel.
//                  master : drives fetch/data/write/cascade, samples outputs
//                  slave  : the tile generator itself
//  Revision    : 1.0  initial release
// ============================================================================
interface cus43_tile_gen_if;
    logic        CLK_2H;   // fetch-phase strobe (period 4 pixel clocks)
    logic        HA2;      // layer A fetch-slot qualifier
    logic        HB2;      // layer B fetch-slot qualifier
    logic [11:0] GDI;      // three bit-planes, 4 pixels each
    logic [7:0]  MDI;      // colour byte at fetch / CPU data on writes
    logic [2:0]  CA;       // register select
    logic        WE;       // write enable
    logic        LATCH;    // write strobe
    logic        FLIP;     // horizontal pixel-order reversal
    logic [2:0]  PRI;      // upstream priority
    logic [7:0]  CLI;      // upstream colour
    logic [2:0]  DTI;      // upstream dot
    logic [2:0]  PRO;      // merged priority
    logic [7:0]  CLO;      // merged colour
    logic [2:0]  DTO;      // merged dot

    modport master (
        output CLK_2H, HA2, HB2, GDI, MDI, CA, WE, LATCH, FLIP, PRI, CLI, DTI,
        input  PRO, CLO, DTO
    );

    modport slave (
        input  CLK_2H, HA2, HB2, GDI, MDI, CA, WE, LATCH, FLIP, PRI, CLI, DTI,
        output PRO, CLO, DTO
    );
endinterface
`default_nettype wire

// File: rtl/cus43_tile_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cus43_tile_gen
//  Description : Two-layer 3bpp tile pixel generator with priority merge.
//                Each layer is loaded with 4 pixels at a fetch edge, shifts
//                out one pixel per pixel clock, and competes by priority with
//                the other layer and the cascaded upstream pixel.
//  Ports       : CLK_6M  - pixel clock
//                RST_N   - asynchronous active-low reset
//                bus     - cus43_tile_gen_if.slave (fetch, data, register
//                          writes, cascade in, merged pixel out)
//  Revision    : 1.0  initial release
// ============================================================================
module cus43_tile_gen #(
    parameter logic [2:0] TRANSP_RST = 3'd7
) (
    input  wire logic           CLK_6M,
    input  wire logic           RST_N,
    cus43_tile_gen_if.slave     bus
);

    localparam int c_NLAYER = 2;

    // Pixel n of a 4-pixel group is the n-th bit of each plane; flipped
    // groups are read back to front.
    function automatic logic [2:0] f_dot(
        input logic [11:0] g,
        input logic [1:0]  cnt,
        input logic        flp
    );
        logic [1:0] n;
        logic [3:0] pl0;
        logic [3:0] pl1;
        logic [3:0] pl2;
        n   = flp ? ~cnt : cnt;
        pl0 = g[3:0];
        pl1 = g[7:4];
        pl2 = g[11:8];
        return {pl2[n], pl1[n], pl0[n]};
    endfunction

    // ------------------------------------------------------------------
    // Fetch edge detection: CLK_2H high now, low on the previous edge
    // ------------------------------------------------------------------
    logic r_2h_prev;
    logic w_fetch;
    logic w_wr;

    always_ff @(posedge CLK_6M or negedge RST_N) begin
        if (!RST_N) begin
            r_2h_prev <= 1'b0;
        end else begin
            r_2h_prev <= bus.CLK_2H;
        end
    end

    assign w_fetch = bus.CLK_2H & ~r_2h_prev;
    assign w_wr    = bus.LATCH & bus.WE;

    // Per-layer results packed as index 0 = layer A, index 1 = layer B
    logic [c_NLAYER-1:0]   w_qual;
    logic [c_NLAYER-1:0]   w_opq_v;
    logic [3*c_NLAYER-1:0] w_dot_v;
    logic [3*c_NLAYER-1:0] w_pri_v;
    logic [8*c_NLAYER-1:0] w_col_v;

    assign w_qual = {bus.HB2, bus.HA2};

    // ------------------------------------------------------------------
    // Layer shifters and their priority / transparent-pen registers.
    // Layer gi owns register addresses gi (priority) and gi+2 (pen).
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < c_NLAYER; gi++) begin : g_layer
        logic [11:0] r_gfx;
        logic [1:0]  r_cnt;
        logic        r_flp;
        logic [7:0]  r_col;
        logic [2:0]  r_pri;
        logic [2:0]  r_pen;

        always_ff @(posedge CLK_6M or negedge RST_N) begin
            if (!RST_N) begin
                r_gfx <= 12'd0;
                r_cnt <= 2'd0;
                r_flp <= 1'b0;
                r_col <= 8'd0;
            end else if (w_fetch && w_qual[gi]) begin
                r_gfx <= bus.GDI;
                r_cnt <= 2'd0;
                r_flp <= bus.FLIP;
                r_col <= bus.MDI;
            end else if (r_cnt != 2'd3) begin
                // Saturate on the last pixel until the next load
                r_cnt <= r_cnt + 2'd1;
            end
        end

        always_ff @(posedge CLK_6M or negedge RST_N) begin
            if (!RST_N) begin
                r_pri <= 3'd0;
                r_pen <= TRANSP_RST;
            end else if (w_wr) begin
                if (bus.CA == 3'(gi)) begin
                    r_pri <= bus.MDI[2:0];
                end
                if (bus.CA == 3'(gi + 2)) begin
                    r_pen <= bus.MDI[2:0];
                end
            end
        end

        assign w_dot_v[3*gi +: 3] = f_dot(r_gfx, r_cnt, r_flp);
        assign w_opq_v[gi]        = (w_dot_v[3*gi +: 3] != r_pen);
        assign w_pri_v[3*gi +: 3] = r_pri;
        assign w_col_v[8*gi +: 8] = r_col;
    end

    // ------------------------------------------------------------------
    // Priority merge. The upstream pixel is the baseline; B replaces it on
    // greater-or-equal priority, then A replaces the current winner on
    // greater-or-equal, giving the A > B > input tie order.
    // ------------------------------------------------------------------
    logic [2:0] w_pro;
    logic [7:0] w_clo;
    logic [2:0] w_dto;

    always_comb begin
        w_pro = bus.PRI;
        w_clo = bus.CLI;
        w_dto = bus.DTI;
        if (w_opq_v[1] && (w_pri_v[5:3] >= w_pro)) begin
            w_pro = w_pri_v[5:3];
            w_clo = w_col_v[15:8];
            w_dto = w_dot_v[5:3];
        end
        if (w_opq_v[0] && (w_pri_v[2:0] >= w_pro)) begin
            w_pro = w_pri_v[2:0];
            w_clo = w_col_v[7:0];
            w_dto = w_dot_v[2:0];
        end
    end

    logic [2:0] r_pro;
    logic [7:0] r_clo;
    logic [2:0] r_dto;

    always_ff @(posedge CLK_6M or negedge RST_N) begin
        if (!RST_N) begin
            r_pro <= 3'd0;
            r_clo <= 8'd0;
            r_dto <= 3'd0;
        end else begin
            r_pro <= w_pro;
            r_clo <= w_clo;
            r_dto <= w_dto;
        end
    end

    assign bus.PRO = r_pro;
    assign bus.CLO = r_clo;
    assign bus.DTO = r_dto;

endmodule
`default_nettype wire

// File: tb/tb_cus43_tile_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cus43_tile_gen
//  Description : Self-checking bench for cus43_tile_gen. Table of per-layer
//                setups with hand-derived 4-pixel results, scoreboard queue
//                keyed by output cycle, plus hand-written sequences for
//                coincident write/fetch, asynchronous reset and reset state.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cus43_tile_gen;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    cus43_tile_gen_if bus_if ();

    cus43_tile_gen #(
        .TRANSP_RST (3'd7)
    ) dut (
        .CLK_6M (clk),
        .RST_N  (rst_n),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // {PRO, CLO, DTO}
    function automatic logic [13:0] px(input logic [2:0] p, input logic [7:0] c, input logic [2:0] d);
        return {p, c, d};
    endfunction

    function automatic logic [3:0][13:0] p4(input logic [13:0] a, input logic [13:0] b,
                                            input logic [13:0] c, input logic [13:0] d);
        return {d, c, b, a};   // a = first pixel
    endfunction

    typedef struct {
        logic [2:0]       pa, pb, na, nb;
        logic [11:0]      ga;
        logic [7:0]       ca;
        logic             fl;
        logic [11:0]      gb;
        logic [7:0]       cb;
        logic [2:0]       pri;
        logic [7:0]       cli;
        logic [2:0]       dti;
        logic [3:0][13:0] ex;
    } vec_t;

    function automatic vec_t mkv(
        input logic [2:0] pa, input logic [2:0] pb, input logic [2:0] na, input logic [2:0] nb,
        input logic [11:0] ga, input logic [7:0] ca, input logic fl,
        input logic [11:0] gb, input logic [7:0] cb,
        input logic [2:0] pri, input logic [7:0] cli, input logic [2:0] dti,
        input logic [3:0][13:0] ex
    );
        vec_t v;
        v.pa = pa; v.pb = pb; v.na = na; v.nb = nb;
        v.ga = ga; v.ca = ca; v.fl = fl; v.gb = gb; v.cb = cb;
        v.pri = pri; v.cli = cli; v.dti = dti; v.ex = ex;
        return v;
    endfunction

    typedef struct {
        int          when;
        logic [13:0] v;
        int          tag;
        int          pix;
    } sb_t;

    sb_t sbq[$];

    task automatic push(input int when, input logic [13:0] v, input int tag, input int pix);
        sb_t e;
        e.when = when; e.v = v; e.tag = tag; e.pix = pix;
        sbq.push_back(e);
    endtask

    // Scoreboard: compare each entry at the negedge following its edge
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].when <= cyc) begin
            sb_t e;
            logic [13:0] got;
            e   = sbq.pop_front();
            got = {bus_if.PRO, bus_if.CLO, bus_if.DTO};
            checks++;
            if (e.when != cyc || got !== e.v) begin
                failures++;
                $display("FAIL sb tag=%0d px=%0d cyc=%0d/%0d got pro=%0d clo=%02h dto=%0d exp pro=%0d clo=%02h dto=%0d",
                         e.tag, e.pix, cyc, e.when, got[13:11], got[10:3], got[2:0],
                         e.v[13:11], e.v[10:3], e.v[2:0]);
            end
        end
    end

    task automatic chk(input string nm, input logic [13:0] exp);
        logic [13:0] got;
        got = {bus_if.PRO, bus_if.CLO, bus_if.DTO};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got pro=%0d clo=%02h dto=%0d exp pro=%0d clo=%02h dto=%0d",
                     nm, got[13:11], got[10:3], got[2:0], exp[13:11], exp[10:3], exp[2:0]);
        end
    endtask

    task automatic wr(input logic [2:0] ca, input logic [2:0] val);
        bus_if.CA    = ca;
        bus_if.MDI   = {5'b10101, val};
        bus_if.LATCH = 1'b1;
        bus_if.WE    = 1'b1;
        @(negedge clk);
        bus_if.LATCH = 1'b0;
        bus_if.WE    = 1'b0;
    endtask

    // One CLK_2H period starting at a negedge with CLK_2H low; the fetch
    // edge is the next posedge. Optional register write coincides with it.
    task automatic fetch(input logic ha, input logic hb, input logic [11:0] g,
                         input logic [7:0] m, input logic fl, input logic w);
        bus_if.CLK_2H = 1'b1;
        bus_if.HA2    = ha;
        bus_if.HB2    = hb;
        bus_if.GDI    = g;
        bus_if.MDI    = m;
        bus_if.FLIP   = fl;
        bus_if.CA     = 3'd0;
        bus_if.LATCH  = w;
        bus_if.WE     = w;
        @(negedge clk);
        bus_if.HA2    = 1'b0;
        bus_if.HB2    = 1'b0;
        bus_if.GDI    = 12'($urandom);
        bus_if.MDI    = 8'($urandom);
        bus_if.FLIP   = 1'($urandom);
        bus_if.LATCH  = 1'b0;
        bus_if.WE     = 1'b0;
        @(negedge clk);
        bus_if.CLK_2H = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic [2:0] p, input logic [7:0] c, input logic [2:0] d);
        bus_if.PRI = p;
        bus_if.CLI = c;
        bus_if.DTI = d;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    vec_t vecs[10];

    initial begin
        int n0;
        cyc      = 0;
        checks   = 0;
        failures = 0;

        // pa pb na nb  ga  ca  fl  gb  cb  pri cli dti  expected pixels 0..3
        vecs[0] = mkv(3'd5, 3'd0, 3'd7, 3'd7, 12'hF0F, 8'h12, 1'b0, 12'hFFF, 8'h99, 3'd0, 8'h55, 3'd2,
                      p4(px(3'd5,8'h12,3'd5), px(3'd5,8'h12,3'd5), px(3'd5,8'h12,3'd5), px(3'd5,8'h12,3'd5)));
        vecs[1] = mkv(3'd3, 3'd0, 3'd7, 3'd7, 12'h421, 8'h21, 1'b0, 12'hFFF, 8'h99, 3'd1, 8'h33, 3'd6,
                      p4(px(3'd3,8'h21,3'd1), px(3'd3,8'h21,3'd2), px(3'd3,8'h21,3'd4), px(3'd3,8'h21,3'd0)));
        vecs[2] = mkv(3'd3, 3'd0, 3'd7, 3'd7, 12'h421, 8'h21, 1'b1, 12'hFFF, 8'h99, 3'd1, 8'h33, 3'd6,
                      p4(px(3'd3,8'h21,3'd0), px(3'd3,8'h21,3'd4), px(3'd3,8'h21,3'd2), px(3'd3,8'h21,3'd1)));
        vecs[3] = mkv(3'd4, 3'd0, 3'd2, 3'd7, 12'h421, 8'h0A, 1'b0, 12'hFFF, 8'h99, 3'd1, 8'h44, 3'd3,
                      p4(px(3'd4,8'h0A,3'd1), px(3'd1,8'h44,3'd3), px(3'd4,8'h0A,3'd4), px(3'd4,8'h0A,3'd0)));
        vecs[4] = mkv(3'd6, 3'd0, 3'd7, 3'd7, 12'hFFF, 8'h77, 1'b0, 12'hFFF, 8'h99, 3'd3, 8'h40, 3'd4,
                      p4(px(3'd3,8'h40,3'd4), px(3'd3,8'h40,3'd4), px(3'd3,8'h40,3'd4), px(3'd3,8'h40,3'd4)));
        vecs[5] = mkv(3'd2, 3'd6, 3'd7, 3'd7, 12'h421, 8'h11, 1'b0, 12'hF0F, 8'hBB, 3'd0, 8'h00, 3'd0,
                      p4(px(3'd6,8'hBB,3'd5), px(3'd6,8'hBB,3'd5), px(3'd6,8'hBB,3'd5), px(3'd6,8'hBB,3'd5)));
        vecs[6] = mkv(3'd2, 3'd2, 3'd7, 3'd7, 12'h421, 8'h11, 1'b0, 12'hF0F, 8'hBB, 3'd0, 8'h00, 3'd0,
                      p4(px(3'd2,8'h11,3'd1), px(3'd2,8'h11,3'd2), px(3'd2,8'h11,3'd4), px(3'd2,8'h11,3'd0)));
        vecs[7] = mkv(3'd1, 3'd2, 3'd7, 3'd7, 12'h421, 8'h11, 1'b0, 12'hF0F, 8'hBB, 3'd3, 8'hC3, 3'd7,
                      p4(px(3'd3,8'hC3,3'd7), px(3'd3,8'hC3,3'd7), px(3'd3,8'hC3,3'd7), px(3'd3,8'hC3,3'd7)));
        vecs[8] = mkv(3'd0, 3'd3, 3'd7, 3'd7, 12'h421, 8'h08, 1'b0, 12'hF0F, 8'hB8, 3'd3, 8'h3C, 3'd1,
                      p4(px(3'd3,8'hB8,3'd5), px(3'd3,8'hB8,3'd5), px(3'd3,8'hB8,3'd5), px(3'd3,8'hB8,3'd5)));
        vecs[9] = mkv(3'd1, 3'd7, 3'd7, 3'd5, 12'h421, 8'h2C, 1'b1, 12'hF0F, 8'h5D, 3'd0, 8'h01, 3'd1,
                      p4(px(3'd1,8'h2C,3'd0), px(3'd1,8'h2C,3'd4), px(3'd1,8'h2C,3'd2), px(3'd1,8'h2C,3'd1)));

        // ---------------- reset state ----------------
        rst_n         = 1'b0;
        bus_if.CLK_2H = 1'b0;
        bus_if.HA2    = 1'b0;
        bus_if.HB2    = 1'b0;
        bus_if.GDI    = 12'h000;
        bus_if.MDI    = 8'h00;
        bus_if.CA     = 3'd0;
        bus_if.WE     = 1'b0;
        bus_if.LATCH  = 1'b0;
        bus_if.FLIP   = 1'b0;
        set_in(3'd0, 8'h55, 3'd2);
        @(negedge clk);
        chk("reset_outputs", px(3'd0, 8'h00, 3'd0));
        @(negedge clk);
        rst_n = 1'b1;
        // No fetch yet: layer A dot 0 is opaque against pen 7 and ties input
        n0 = cyc;
        for (int k = 1; k <= 3; k++) push(n0 + k, px(3'd0, 8'h00, 3'd0), 90, k);
        repeat (3) @(negedge clk);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 10; i++) begin
            wr(3'd0, vecs[i].pa);
            wr(3'd1, vecs[i].pb);
            wr(3'd2, vecs[i].na);
            wr(3'd3, vecs[i].nb);
            // Unused addresses must not alias onto the real registers
            for (int k = 4; k < 8; k++) wr(3'(k), 3'd7);
            set_in(vecs[i].pri, vecs[i].cli, vecs[i].dti);
            fetch(1'b0, 1'b1, vecs[i].gb, vecs[i].cb, 1'b0, 1'b0);
            n0 = cyc;
            for (int k = 0; k < 4; k++) push(n0 + 2 + k, vecs[i].ex[k], i, k);
            push(n0 + 6, vecs[i].ex[3], i, 4);   // last pixel held
            fetch(1'b1, 1'b0, vecs[i].ga, vecs[i].ca, vecs[i].fl, 1'b0);
            repeat (2) @(negedge clk);
        end

        // ---------------- write coinciding with fetch edge ----------------
        wr(3'd0, 3'd0);
        set_in(3'd5, 8'h66, 3'd3);
        n0 = cyc;
        push(n0 + 2, px(3'd6, 8'h06, 3'd1), 100, 0);
        push(n0 + 3, px(3'd6, 8'h06, 3'd2), 100, 1);
        push(n0 + 4, px(3'd6, 8'h06, 3'd4), 100, 2);
        push(n0 + 5, px(3'd6, 8'h06, 3'd0), 100, 3);
        fetch(1'b1, 1'b0, 12'h421, 8'h06, 1'b0, 1'b1);
        repeat (2) @(negedge clk);

        // ---------------- asynchronous reset mid-shift ----------------
        wr(3'd0, 3'd5);
        set_in(3'd0, 8'h55, 3'd2);
        bus_if.CLK_2H = 1'b1;
        bus_if.HA2    = 1'b1;
        bus_if.GDI    = 12'hF0F;
        bus_if.MDI    = 8'h12;
        bus_if.FLIP   = 1'b0;
        @(negedge clk);
        bus_if.HA2    = 1'b0;
        @(negedge clk);
        chk("pre_reset_pixel0", px(3'd5, 8'h12, 3'd5));
        bus_if.CLK_2H = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_immediate", px(3'd0, 8'h00, 3'd0));
        @(negedge clk);
        chk("reset_held", px(3'd0, 8'h00, 3'd0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_first", px(3'd0, 8'h00, 3'd0));

        // Pens back at reset value: A all-7 is transparent, B dot 0 opaque
        n0 = cyc;
        for (int k = 0; k < 4; k++) push(n0 + 2 + k, px(3'd0, 8'h00, 3'd0), 110, k);
        fetch(1'b1, 1'b0, 12'hFFF, 8'h9A, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // ---------------- drain ----------------
        for (int k = 0; k < 50 && sbq.size() > 0; k++) @(negedge clk);
        if (sbq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
